// File: rtl/prod_bcd_display_pkg.sv
// prod_bcd_display_pkg: shared widths, BCD/segment types, converter states and active-low {g..a} digit patterns
package prod_bcd_display_pkg;
  localparam int DW2 = 16;
  localparam int DIGITS = 5;
  localparam int CNT_W = $clog2(DW2 + 1);
  typedef logic [4*DIGITS-1:0] bcd_t;
  typedef logic [6:0] seg_t;
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} bcd_state_t;
  localparam seg_t SEG_0 = 7'h40;
  localparam seg_t SEG_1 = 7'h79;
  localparam seg_t SEG_2 = 7'h24;
  localparam seg_t SEG_3 = 7'h30;
  localparam seg_t SEG_4 = 7'h19;
  localparam seg_t SEG_5 = 7'h12;
  localparam seg_t SEG_6 = 7'h02;
  localparam seg_t SEG_7 = 7'h78;
  localparam seg_t SEG_8 = 7'h00;
  localparam seg_t SEG_9 = 7'h10;
  localparam seg_t SEG_OFF = 7'h7F;
endpackage

// File: rtl/prod_bcd_display_seg7_decoder.sv
// prod_bcd_display_seg7_decoder: combinational BCD nibble (nib) to active-low {g..a} segments (seg); 10-15 are dark
module prod_bcd_display_seg7_decoder
  import prod_bcd_display_pkg::*;
(
  input  logic [3:0] nib,
  output logic [6:0] seg
);
  always_comb
    seg = nib == 4'd0 ? SEG_0 :
          nib == 4'd1 ? SEG_1 :
          nib == 4'd2 ? SEG_2 :
          nib == 4'd3 ? SEG_3 :
          nib == 4'd4 ? SEG_4 :
          nib == 4'd5 ? SEG_5 :
          nib == 4'd6 ? SEG_6 :
          nib == 4'd7 ? SEG_7 :
          nib == 4'd8 ? SEG_8 :
          nib == 4'd9 ? SEG_9 : SEG_OFF;
endmodule

// File: rtl/prod_bcd_display.sv
// prod_bcd_display: sequential double-dabble of product/sign on start into held bcd, active-low seg and seg_minus with busy/done; LEADING_ZERO_BLANK_EN darkens leading zero digits
module prod_bcd_display
  import prod_bcd_display_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [DW2-1:0]        product,
  input  logic                  sign,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd,
  output logic [7*DIGITS-1:0]   seg,
  output logic                  seg_minus
);
  localparam int SW = 4*DIGITS + DW2;
  bcd_state_t state_q, state_d;
  logic [SW-1:0] sr_q, sr_d, adj;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic neg_q, neg_d, minus_q, minus_d, valid_q, valid_d;
  bcd_t bcd_q, bcd_d;
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sr_q <= '0;
      cnt_q <= '0;
      neg_q <= 1'b0;
      minus_q <= 1'b1;
      valid_q <= 1'b0;
      bcd_q <= '0;
    end else begin
      state_q <= state_d;
      sr_q <= sr_d;
      cnt_q <= cnt_d;
      neg_q <= neg_d;
      minus_q <= minus_d;
      valid_q <= valid_d;
      bcd_q <= bcd_d;
    end
  end
  always_comb begin
    adj = sr_q;
    for (int i = 0; i < DIGITS; i++)
      adj[DW2+4*i +: 4] = sr_q[DW2+4*i +: 4] >= 4'd5 ? sr_q[DW2+4*i +: 4] + 4'd3 : sr_q[DW2+4*i +: 4];
    state_d = state_q;
    sr_d = sr_q;
    cnt_d = cnt_q;
    neg_d = neg_q;
    minus_d = minus_q;
    valid_d = valid_q;
    bcd_d = bcd_q;
    case (state_q)
      IDLE: if (start) begin
        state_d = SHIFT;
        sr_d = {{(4*DIGITS){1'b0}}, product};
        cnt_d = '0;
        neg_d = sign & (product != '0);
      end
      SHIFT: begin
        sr_d = adj << 1;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(DW2 - 1)) begin
          state_d = DONE;
          bcd_d = sr_d[SW-1:DW2];
          minus_d = ~neg_q;
          valid_d = 1'b1;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  assign busy = state_q == SHIFT;
  assign done = state_q == DONE;
  assign bcd = bcd_q;
  assign seg_minus = minus_q;
  for (genvar d = 0; d < DIGITS; d++) begin : g_dig
    logic [6:0] dec;
    logic lit;
    prod_bcd_display_seg7_decoder u_dec (.nib(bcd_q[4*d +: 4]), .seg(dec));
`ifdef LEADING_ZERO_BLANK_EN
    assign lit = d == 0 || bcd_q[4*DIGITS-1:4*d] != '0;
`else
    assign lit = 1'b1;
`endif
    assign seg[7*d +: 7] = valid_q && lit ? dec : SEG_OFF;
  end
endmodule

// File: tb/tb_prod_bcd_display.sv
// tb_prod_bcd_display: directed table, corner sequences and random products checked against an arithmetic model
module tb_prod_bcd_display;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic [15:0] product = '0;
  logic sign = 1'b0;
  logic busy, done, seg_minus;
  logic [19:0] bcd;
  logic [34:0] seg;
  int total = 0;
  int bad = 0;
  logic [19:0] prev_bcd = '0;
  logic prev_minus = 1'b1;
  localparam logic [6:0] PAT [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
  typedef struct {
    logic [15:0] p;
    logic        s;
    logic [19:0] eb;
    logic        em;
  } vec_t;
  vec_t tbl [6];

  prod_bcd_display dut (
    .clk(clk), .rst(rst), .start(start), .product(product), .sign(sign),
    .busy(busy), .done(done), .bcd(bcd), .seg(seg), .seg_minus(seg_minus)
  );

  always #5 clk = ~clk;

  function automatic logic [19:0] ref_bcd(input int n);
    logic [19:0] r;
    int pw = 1;
    for (int i = 0; i < 5; i++) begin
      r[4*i +: 4] = 4'((n / pw) % 10);
      pw = pw * 10;
    end
    return r;
  endfunction

  function automatic logic [34:0] ref_seg(input int n);
    logic [34:0] r;
    logic lit;
    int pw = 1;
    for (int i = 0; i < 5; i++) begin
      lit = 1'b1;
`ifdef LEADING_ZERO_BLANK_EN
      lit = i == 0 || n >= pw;
`endif
      r[7*i +: 7] = lit ? PAT[(n / pw) % 10] : 7'h7F;
      pw = pw * 10;
    end
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  task automatic run_conv(input logic [15:0] p, input logic s);
    int lat = 0;
    bit hold_ok = 1'b1;
    bit busy_ok = 1'b1;
    @(negedge clk);
    start = 1'b1;
    product = p;
    sign = s;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      start = 1'b0;
      product = 16'($urandom);
      sign = 1'($urandom);
      if (done) begin
        lat = c;
        break;
      end
      if (!busy) busy_ok = 1'b0;
      if (bcd !== prev_bcd || seg_minus !== prev_minus) hold_ok = 1'b0;
    end
    chk("latency", 64'(lat), 64'd17);
    chk("busy_during", 64'(busy_ok), 64'd1);
    chk("hold_old", 64'(hold_ok), 64'd1);
    chk("busy_at_done", 64'(busy), 64'd0);
    chk("bcd", 64'(bcd), 64'(ref_bcd(int'(p))));
    chk("seg", 64'(seg), 64'(ref_seg(int'(p))));
    chk("seg_minus", 64'(seg_minus), 64'(!(s && p != 0)));
    prev_bcd = ref_bcd(int'(p));
    prev_minus = !(s && p != 0);
    @(negedge clk);
    chk("done_one_cycle", 64'(done), 64'd0);
  endtask

  initial begin
    int ndone;
    int first;
    logic [15:0] rp;
    tbl[0] = '{16'd0,     1'b0, 20'h00000, 1'b1};
    tbl[1] = '{16'd12345, 1'b1, 20'h12345, 1'b0};
    tbl[2] = '{16'hFFFF,  1'b0, 20'h65535, 1'b1};
    tbl[3] = '{16'd0,     1'b1, 20'h00000, 1'b1};
    tbl[4] = '{16'd9,     1'b1, 20'h00009, 1'b0};
    tbl[5] = '{16'd10000, 1'b0, 20'h10000, 1'b1};
    repeat (2) @(negedge clk);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_bcd", 64'(bcd), 64'd0);
    chk("rst_seg", 64'(seg), 64'h7_FFFF_FFFF);
    chk("rst_minus", 64'(seg_minus), 64'd1);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      run_conv(tbl[i].p, tbl[i].s);
      chk("tbl_bcd", 64'(bcd), 64'(tbl[i].eb));
      chk("tbl_minus", 64'(seg_minus), 64'(tbl[i].em));
      if (i == 0) chk("tbl_dig0_seg", 64'(seg[6:0]), 64'h40);
      if (i == 2) chk("tbl_dig4_seg", 64'(seg[34:28]), 64'h02);
    end
    @(negedge clk);
    start = 1'b1;
    product = 16'd42;
    sign = 1'b0;
    ndone = 0;
    first = 0;
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
      start = c == 5;
      product = c == 5 ? 16'd999 : 16'd0;
      if (done) begin
        ndone++;
        if (first == 0) first = c;
      end
    end
    start = 1'b0;
    chk("ign_ndone", 64'(ndone), 64'd1);
    chk("ign_latency", 64'(first), 64'd17);
    chk("ign_bcd", 64'(bcd), 64'h00042);
    prev_bcd = 20'h00042;
    prev_minus = 1'b1;
    @(negedge clk);
    start = 1'b1;
    product = 16'd500;
    sign = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      start = 1'b0;
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_done", 64'(done), 64'd0);
    chk("mid_rst_bcd", 64'(bcd), 64'd0);
    chk("mid_rst_seg", 64'(seg), 64'h7_FFFF_FFFF);
    chk("mid_rst_minus", 64'(seg_minus), 64'd1);
    ndone = 0;
    for (int c = 1; c <= 25; c++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    chk("mid_rst_nodone", 64'(ndone), 64'd0);
    prev_bcd = '0;
    prev_minus = 1'b1;
    run_conv(16'd7, 1'b0);
    chk("after_rst_bcd", 64'(bcd), 64'h00007);
`ifdef LEADING_ZERO_BLANK_EN
    chk("after_rst_upper", 64'(seg[34:7]), 64'hFFF_FFFF);
`else
    chk("after_rst_upper", 64'(seg[34:7]), 64'h810_2040);
`endif
    for (int k = 0; k < 20; k++) begin
      rp = $urandom_range(0, 2) == 0 ? 16'($urandom_range(0, 999)) : 16'($urandom);
      run_conv(rp, 1'($urandom));
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
